// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: refill FSM state encoding, line offset macro
// and the bundle of stall/flush controls.
`ifndef FC_LINE_OFF_W
`define FC_LINE_OFF_W(lw) ($clog2(lw) + 2)
`endif

package fetch_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_REQ  = 2'd1,
    FC_FILL = 2'd2,
    FC_DONE = 2'd3
  } fc_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic flush_pipe_and_pc;
  } fc_ctl_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller signal bundle: IF-stage/branch/hazard inputs, memory bus,
// cache refill port and pipeline controls. master = controller, slave = environment.
interface fetch_ctrl_if #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
);
  import fetch_ctrl_pkg::*;

  logic                          imiss;
  logic [ADDR_W-1:0]             miss_addr;
  logic                          mispredict;
  logic                          load_use_haz;
  logic                          mem_req;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_gnt;
  logic                          mem_rvalid;
  logic [DATA_W-1:0]             mem_rdata;
  logic                          refill_we;
  logic [$clog2(LINE_WORDS)-1:0] refill_word;
  logic [DATA_W-1:0]             refill_data;
  logic                          refill_done;
  logic                          pc_stall;
  logic                          if_id_stall;
  logic                          if_id_flush;
  logic                          flush_pipe_and_pc;
  logic                          busy;
  logic [31:0]                   miss_cycles;

  modport master (
    input  imiss, miss_addr, mispredict, load_use_haz, mem_gnt, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, refill_we, refill_word, refill_data, refill_done,
           pc_stall, if_id_stall, if_id_flush, flush_pipe_and_pc, busy, miss_cycles
  );

  modport slave (
    output imiss, miss_addr, mispredict, load_use_haz, mem_gnt, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr, refill_we, refill_word, refill_data, refill_done,
           pc_stall, if_id_stall, if_id_flush, flush_pipe_and_pc, busy, miss_cycles
  );

endinterface

// File: rtl/fetch_refill_fsm.sv
// I-cache line refill sequencer: latches the missing line, requests it from memory,
// streams beats into the cache and pulses completion.
module fetch_refill_fsm
  import fetch_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imiss,
  input  logic [ADDR_W-1:0]             miss_addr,
  input  logic                          mispredict,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word,
  output logic [DATA_W-1:0]             refill_data,
  output logic                          refill_done,
  output fc_state_e                     state
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = `FC_LINE_OFF_W(LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  fc_state_e          state_q, state_d;
  logic [WORD_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0]  line_q, line_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FC_IDLE;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    mem_req     = 1'b0;
    refill_we   = 1'b0;
    refill_data = '0;
    refill_done = 1'b0;
    case (state_q)
      FC_IDLE: begin
        // a miss alongside a redirect is on the wrong path
        if (imiss && !mispredict) begin
          line_d  = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = FC_REQ;
        end
      end
      FC_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          beat_d  = '0;
          state_d = FC_FILL;
        end
      end
      FC_FILL: begin
        if (mem_rvalid) begin
          refill_we   = 1'b1;
          refill_data = mem_rdata;
          beat_d      = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = FC_DONE;
        end
      end
      FC_DONE: begin
        refill_done = 1'b1;
        state_d     = FC_IDLE;
      end
      default: state_d = FC_IDLE;
    endcase
  end

  assign mem_addr    = line_q;
  assign refill_word = beat_q;
  assign state       = state_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: refill FSM plus fixed-priority stall/flush
// (mispredict > load-use > I-miss). Optional miss-cycle counter under FETCH_PERF_CNT_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);

  fc_state_e state;
  logic      miss_stall;
  fc_ctl_t   ctl;

  fetch_refill_fsm #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_refill (
    .clk         (clk),
    .rst_n       (rst_n),
    .imiss       (bus.imiss),
    .miss_addr   (bus.miss_addr),
    .mispredict  (bus.mispredict),
    .mem_gnt     (bus.mem_gnt),
    .mem_rvalid  (bus.mem_rvalid),
    .mem_rdata   (bus.mem_rdata),
    .mem_req     (bus.mem_req),
    .mem_addr    (bus.mem_addr),
    .refill_we   (bus.refill_we),
    .refill_word (bus.refill_word),
    .refill_data (bus.refill_data),
    .refill_done (bus.refill_done),
    .state       (state)
  );

  assign miss_stall = (state != FC_IDLE) | (bus.imiss & ~bus.mispredict);

  // controls are combinational but must read 0 throughout reset
  always_comb begin
    ctl = '0;
    if (rst_n) begin
      ctl.flush_pipe_and_pc = bus.mispredict;
      ctl.pc_stall          = ~bus.mispredict & (bus.load_use_haz | miss_stall);
      ctl.if_id_stall       = ~bus.mispredict & bus.load_use_haz;
      ctl.if_id_flush       = bus.mispredict | (~bus.load_use_haz & miss_stall);
    end
  end

  assign bus.pc_stall          = ctl.pc_stall;
  assign bus.if_id_stall       = ctl.if_id_stall;
  assign bus.if_id_flush       = ctl.if_id_flush;
  assign bus.flush_pipe_and_pc = ctl.flush_pipe_and_pc;
  assign bus.busy              = (state != FC_IDLE);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] miss_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      miss_cycles_q <= '0;
    else if (miss_stall && !bus.mispredict && (miss_cycles_q != '1))
      miss_cycles_q <= miss_cycles_q + 32'd1;
  end

  assign bus.miss_cycles = miss_cycles_q;
`else
  assign bus.miss_cycles = '0;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the instruction-fetch stage.
- Owns the I-cache miss refill: requests the line from memory, streams the beats into the cache, and signals completion.
- Generates the PC stall, IF/ID stall, IF/ID flush and pipe+PC flush controls.
- Arbitrates three sources in fixed priority: branch mispredict, then load-use hazard, then I-miss.
- Sits between the IF stage, the branch unit, the decode hazard detector and the memory bus.

Parameters:
- LINE_WORDS, 4: 32-bit words per cache line; must be a power of 2, ≥2.
- ADDR_W, 32: instruction address width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous active-low reset (0 = reset).
- Imiss  in  1  I-cache miss for the current fetch address.
- MissAddr  in  ADDR_W  fetch address that missed.
- Mispredict  in  1  branch unit redirect request (one-cycle pulse).
- LoadUseHaz  in  1  decode hazard requests a hold of IF and IF/ID.
- MemReq  out  1  line read request.
- MemAddr  out  ADDR_W  line-aligned request address.
- MemGnt  in  1  memory accepts the request.
- MemRValid  in  1  read data beat valid.
- MemRData  in  32  read data beat.
- RefillWe  out  1  cache word write enable.
- RefillWord  out  log2(LINE_WORDS)  word index within the line.
- RefillData  out  32  word to write.
- RefillDone  out  1  one-cycle pulse; cache sets tag/valid.
- PCStall  out  1  hold PC.
- IF_ID_Stall  out  1  hold the IF/ID register.
- IF_ID_Flush  out  1  load a bubble into IF/ID.
- FlushPipeandPC  out  1  redirect PC to the jump target and flush younger stages.
- Busy  out  1  refill in progress (state != IDLE).
- MissCycles  out  32  miss-stall cycle count (optional feature).

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, beat counter=0, line address=0. All outputs 0 while Rst=0, including the combinational stall/flush outputs.
- Reset mid-refill: MemReq drops immediately. Beats arriving after reset are ignored, because MemRValid is ignored outside FILL.
- FSM states: IDLE, REQ, FILL, DONE (registered).
- IDLE:
  - Imiss=1 and Mispredict=0 → latch line address = MissAddr with the low log2(LINE_WORDS)+2 bits cleared; next state REQ.
  - Imiss together with Mispredict → the miss is wrong-path; ignore it and stay in IDLE.
- REQ:
  - MemReq=1; MemAddr holds the latched line address.
  - MemGnt=1 → next state FILL, beat counter=0.
  - MemRValid in REQ is ignored.
- FILL:
  - Each MemRValid=1 cycle: RefillWe=1, RefillWord=counter, RefillData=MemRData (combinational passthrough), counter+1.
  - Beat with counter=LINE_WORDS-1 → next state DONE. Counter wraps to 0.
  - Cycles with no beat: hold.
- DONE: RefillDone=1 for one cycle → IDLE. The re-fetch hits on the following cycle.
- Latency: a miss with grant in cycle 0 and back-to-back beats finishes in LINE_WORDS+3 cycles from Imiss to IDLE.
- missStall = (state!=IDLE) | (state==IDLE & Imiss & !Mispredict).
- Output priority, with all control outputs combinational:
  - FlushPipeandPC = Mispredict.
  - PCStall = !Mispredict & (LoadUseHaz | missStall).
  - IF_ID_Stall = !Mispredict & LoadUseHaz.
  - IF_ID_Flush = Mispredict | (!LoadUseHaz & missStall). This inserts a bubble while decode drains.
- Mispredict during REQ/FILL/DONE:
  - The redirect takes effect that cycle, so PC loads the target.
  - The refill is not aborted (the bus is not abortable) and completes normally with RefillDone. The line data is valid, so there is no side effect.
  - PCStall returns to 1 on the next cycle until the refill completes. A miss at the new PC then starts a fresh refill.
- LoadUseHaz during a refill: IF/ID stalls instead of flushes; the refill continues.
- MemGnt and MemRValid are ignored in IDLE and DONE.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: MissCycles counts the cycles in which missStall=1 and Mispredict=0. It saturates at 0xFFFFFFFF and clears on reset.
- Undefined: MissCycles is tied to 0 and no counter flops exist.

Decomposition:
- Shared pipeline defines header holds:
  - State encodings FC_IDLE=2'd0, FC_REQ=2'd1, FC_FILL=2'd2, FC_DONE=2'd3.
  - Macro for the line offset width.
- One sub-module, fetch_refill_fsm: the FSM, beat counter, line address latch and memory/cache refill ports.
- fetch_ctrl top: the priority stall/flush logic and the optional counter.

Test Plan:
- Miss at 0x0000_1234, MemGnt at cycle 2, 4 back-to-back beats 0xA0..0xA3:
  - MemAddr=0x0000_1230.
  - RefillWord 0,1,2,3 carry 0xA0..0xA3.
  - RefillDone pulses once.
  - PCStall=1 and IF_ID_Flush=1 throughout, then 0 in the cycle after DONE.
- Beats with 2-cycle gaps: RefillWe only on valid cycles; the counter holds during gaps; exactly 4 writes.
- Mispredict in FILL after beat 1: that cycle FlushPipeandPC=1, IF_ID_Flush=1, PCStall=0; the remaining beats still written; RefillDone pulses.
- Imiss and Mispredict in the same IDLE cycle: state stays IDLE, MemReq=0, FlushPipeandPC=1.
- LoadUseHaz during FILL: IF_ID_Stall=1, IF_ID_Flush=0, PCStall=1.
- Rst=0 asserted after beat 2: MemReq and all outputs 0 immediately; after release, a stray MemRValid does not produce RefillWe; with FETCH_PERF_CNT_EN, MissCycles=0.
